// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered, flow-controlled immediate generator for the decode stage.
// Extracts the immediate from instruction bits [31:7] for eight formats,
// extends it to XLEN and buffers it behind a valid/ready handshake with a
// two-entry skid buffer (main + skid) and a synchronous flush.
//
// Optional feature macro: IMM_GEN_TARGET_EN
//   When defined, pc_i and target_o exist and each entry also carries the
//   PC-relative target pc_i + imm (XLEN-bit wrap-around).
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the opaque sideband carried with each immediate
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous flush, drops every buffered entry
//   in_valid_i   input entry valid
//   in_ready_o   block can accept an entry this cycle
//   instr_i      instruction bits [31:7]
//   type_i       format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH
//   tag_i        sideband in
//   pc_i         instruction PC (IMM_GEN_TARGET_EN only)
//   out_valid_o  output entry valid
//   out_ready_i  consumer accepts the output entry
//   imm_o        extended immediate
//   tag_o        sideband out
//   target_o     pc_i + imm (IMM_GEN_TARGET_EN only)

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      instr_i,
  input  logic [2:0]       type_i,
  input  logic [TAG_W-1:0] tag_i,
`ifdef IMM_GEN_TARGET_EN
  input  logic [XLEN-1:0]  pc_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
`ifdef IMM_GEN_TARGET_EN
  output logic [TAG_W-1:0] tag_o,
  output logic [XLEN-1:0]  target_o
`else
  output logic [TAG_W-1:0] tag_o
`endif
);

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_Z  = 3'd6,
    FMT_SH = 3'd7
  } fmt_e;

  // instr_i[k-7] holds instruction bit k, so bit 31 (sign) is instr_i[24].
  logic            sign;
  logic [31:0]     imm32;
  logic            immSext;
  logic [XLEN-1:0] immNew;

  // Every format fits in 32 bits; the result is then sign- or zero-extended
  // to XLEN in one place. U is sign-extended, which gives bits 63:32 = s.
  always_comb begin
    sign    = instr_i[24];
    imm32   = 32'd0;
    immSext = 1'b1;
    case (fmt_e'(type_i))
      FMT_R:  imm32 = 32'd0;
      FMT_I:  imm32 = {{20{sign}}, instr_i[24:13]};
      FMT_S:  imm32 = {{20{sign}}, instr_i[24:18], instr_i[4:0]};
      FMT_B:  imm32 = {{19{sign}}, sign, instr_i[0], instr_i[23:18],
                       instr_i[4:1], 1'b0};
      FMT_U:  imm32 = {instr_i[24:5], 12'd0};
      FMT_J:  imm32 = {{11{sign}}, sign, instr_i[12:5], instr_i[13],
                       instr_i[23:14], 1'b0};
      FMT_Z: begin
        imm32   = {27'd0, instr_i[12:8]};
        immSext = 1'b0;
      end
      FMT_SH: begin
        // RV64 shift amounts use one more bit than RV32.
        if (XLEN == 64) imm32 = {26'd0, instr_i[18:13]};
        else            imm32 = {27'd0, instr_i[17:13]};
        immSext = 1'b0;
      end
      default: imm32 = 32'd0;
    endcase
    if (immSext) immNew = XLEN'($signed(imm32));
    else         immNew = XLEN'(imm32);
  end

`ifdef IMM_GEN_TARGET_EN
  logic [XLEN-1:0] targetNew;
  assign targetNew = pc_i + immNew;
`endif

  logic             mainValid_q, mainValid_d;
  logic             skidValid_q, skidValid_d;
  logic [XLEN-1:0]  mainImm_q, mainImm_d;
  logic [XLEN-1:0]  skidImm_q, skidImm_d;
  logic [TAG_W-1:0] mainTag_q, mainTag_d;
  logic [TAG_W-1:0] skidTag_q, skidTag_d;
`ifdef IMM_GEN_TARGET_EN
  logic [XLEN-1:0]  mainTarget_q, mainTarget_d;
  logic [XLEN-1:0]  skidTarget_q, skidTarget_d;
`endif

  logic accept;
  logic deliver;

  // in_ready_o depends only on registered state, so out_ready_i never has a
  // combinational path to the upstream stage.
  assign in_ready_o = !skidValid_q;
  assign accept     = in_valid_i && in_ready_o;
  assign deliver    = mainValid_q && out_ready_i;

  // Buffer control. A delivery with a full skid refills main from skid; no
  // input can arrive then because in_ready_o is low. Otherwise a new entry
  // goes into main if main is empty or draining, else into skid. Flush only
  // clears the valid bits; payload registers keep stale data.
  always_comb begin
    mainValid_d  = mainValid_q;
    skidValid_d  = skidValid_q;
    mainImm_d    = mainImm_q;
    skidImm_d    = skidImm_q;
    mainTag_d    = mainTag_q;
    skidTag_d    = skidTag_q;
`ifdef IMM_GEN_TARGET_EN
    mainTarget_d = mainTarget_q;
    skidTarget_d = skidTarget_q;
`endif
    if (flush_i) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (deliver && skidValid_q) begin
      mainValid_d  = 1'b1;
      skidValid_d  = 1'b0;
      mainImm_d    = skidImm_q;
      mainTag_d    = skidTag_q;
`ifdef IMM_GEN_TARGET_EN
      mainTarget_d = skidTarget_q;
`endif
    end else if (accept && (!mainValid_q || deliver)) begin
      mainValid_d  = 1'b1;
      mainImm_d    = immNew;
      mainTag_d    = tag_i;
`ifdef IMM_GEN_TARGET_EN
      mainTarget_d = targetNew;
`endif
    end else if (accept) begin
      skidValid_d  = 1'b1;
      skidImm_d    = immNew;
      skidTag_d    = tag_i;
`ifdef IMM_GEN_TARGET_EN
      skidTarget_d = targetNew;
`endif
    end else if (deliver) begin
      mainValid_d = 1'b0;
    end
  end

  // State registers; reset empties both entries and zeroes the payload so
  // the outputs read zero during and right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mainValid_q  <= 1'b0;
      skidValid_q  <= 1'b0;
      mainImm_q    <= '0;
      skidImm_q    <= '0;
      mainTag_q    <= '0;
      skidTag_q    <= '0;
`ifdef IMM_GEN_TARGET_EN
      mainTarget_q <= '0;
      skidTarget_q <= '0;
`endif
    end else begin
      mainValid_q  <= mainValid_d;
      skidValid_q  <= skidValid_d;
      mainImm_q    <= mainImm_d;
      skidImm_q    <= skidImm_d;
      mainTag_q    <= mainTag_d;
      skidTag_q    <= skidTag_d;
`ifdef IMM_GEN_TARGET_EN
      mainTarget_q <= mainTarget_d;
      skidTarget_q <= skidTarget_d;
`endif
    end
  end

  assign out_valid_o = mainValid_q;
  assign imm_o       = mainImm_q;
  assign tag_o       = mainTag_q;
`ifdef IMM_GEN_TARGET_EN
  assign target_o    = mainTarget_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the
// same stimulus. Directed vectors with hand-computed expected values.
// Target checks are compiled in when IMM_GEN_TARGET_EN is defined.

module tb_imm_gen_pipe;

  localparam int TAG_W = 8;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_Z  = 3'd6;
  localparam logic [2:0] FMT_SH = 3'd7;

  logic             clock = 1'b0;
  logic             rstN;
  logic             flush;
  logic             inValid;
  logic             outReady;
  logic [24:0]      instr;
  logic [2:0]       instrType;
  logic [TAG_W-1:0] tagIn;

  logic             inReady32, outValid32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             inReady64, outValid64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;
`ifdef IMM_GEN_TARGET_EN
  logic [31:0]      pc32;
  logic [63:0]      pc64;
  logic [31:0]      target32;
  logic [63:0]      target64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk_i       (clock),
    .rst_ni      (rstN),
    .flush_i     (flush),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady32),
    .instr_i     (instr),
    .type_i      (instrType),
    .tag_i       (tagIn),
`ifdef IMM_GEN_TARGET_EN
    .pc_i        (pc32),
    .target_o    (target32),
`endif
    .out_valid_o (outValid32),
    .out_ready_i (outReady),
    .imm_o       (imm32),
    .tag_o       (tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk_i       (clock),
    .rst_ni      (rstN),
    .flush_i     (flush),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady64),
    .instr_i     (instr),
    .type_i      (instrType),
    .tag_i       (tagIn),
`ifdef IMM_GEN_TARGET_EN
    .pc_i        (pc64),
    .target_o    (target64),
`endif
    .out_valid_o (outValid64),
    .out_ready_i (outReady),
    .imm_o       (imm64),
    .tag_o       (tag64)
  );

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to 1 time unit after the next edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] word,
                               input logic [2:0] fmt, input logic [7:0] tag,
                               input logic ready, input logic fl);
    inValid   = valid;
    instr     = word[31:7];
    instrType = fmt;
    tagIn     = tag;
    outReady  = ready;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rstN      = 1'b0;
    flush     = 1'b0;
    inValid   = 1'b0;
    outReady  = 1'b1;
    instr     = '0;
    instrType = FMT_R;
    tagIn     = '0;
`ifdef IMM_GEN_TARGET_EN
    pc32 = 32'hFFFF_FFF0;
    pc64 = 64'hFFFF_FFFF_FFFF_FFF0;
`endif
    #1;
    checkOutput("rst_valid", {63'd0, outValid32}, 64'd0);
    checkOutput("rst_ready", {63'd0, inReady32}, 64'd1);
    checkOutput("rst_imm32", {32'd0, imm32}, 64'd0);
    checkOutput("rst_tag",   {56'd0, tag32}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    rstN = 1'b1;
    checkOutput("post_rst_ready", {63'd0, inReady32}, 64'd1);

    // Back-to-back formats with out_ready held high: one entry per cycle.
    applyStimulus(1'b1, 32'hFFF0_0093, FMT_I, 8'd1, 1'b1, 1'b0);
    checkOutput("i_valid", {63'd0, outValid32}, 64'd1);
    checkOutput("i_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("i_tag",   {56'd0, tag32}, 64'd1);
    applyStimulus(1'b1, 32'hFE00_0EE3, FMT_B, 8'd2, 1'b1, 1'b0);
    checkOutput("b_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
    checkOutput("b_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("b_tag",   {56'd0, tag32}, 64'd2);
    applyStimulus(1'b1, 32'h1234_5037, FMT_U, 8'd3, 1'b1, 1'b0);
    checkOutput("u_imm32", {32'd0, imm32}, 64'h0000_0000_1234_5000);
    checkOutput("u_imm64", imm64, 64'h0000_0000_1234_5000);
    applyStimulus(1'b1, 32'h000F_D073, FMT_Z, 8'd4, 1'b1, 1'b0);
    checkOutput("z_imm32", {32'd0, imm32}, 64'h1F);
    checkOutput("z_imm64", imm64, 64'h1F);
    applyStimulus(1'b1, 32'h8000_0037, FMT_U, 8'd5, 1'b1, 1'b0);
    checkOutput("uneg_imm32", {32'd0, imm32}, 64'h0000_0000_8000_0000);
    checkOutput("uneg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(1'b1, 32'h03F0_1013, FMT_SH, 8'd6, 1'b1, 1'b0);
    checkOutput("sh_imm32", {32'd0, imm32}, 64'h1F);
    checkOutput("sh_imm64", imm64, 64'h3F);
    applyStimulus(1'b1, 32'h0011_2423, FMT_S, 8'd7, 1'b1, 1'b0);
    checkOutput("s_imm32", {32'd0, imm32}, 64'h8);
    applyStimulus(1'b1, 32'h0200_006F, FMT_J, 8'd8, 1'b1, 1'b0);
    checkOutput("j_imm32", {32'd0, imm32}, 64'h20);
    checkOutput("j_imm64", imm64, 64'h20);
`ifdef IMM_GEN_TARGET_EN
    checkOutput("j_target32", {32'd0, target32}, 64'h10);
    checkOutput("j_target64", target64, 64'h10);
`endif
    applyStimulus(1'b1, 32'hFFFF_FFFF, FMT_R, 8'd9, 1'b1, 1'b0);
    checkOutput("r_imm32", {32'd0, imm32}, 64'd0);
    checkOutput("r_imm64", imm64, 64'd0);
    checkOutput("r_tag",   {56'd0, tag32}, 64'd9);
    applyStimulus(1'b0, 32'd0, FMT_R, 8'd0, 1'b1, 1'b0);
    checkOutput("drain_valid", {63'd0, outValid32}, 64'd0);

    // Backpressure: tag n carries I-immediate n; out_ready low cycles 2-3.
    applyStimulus(1'b1, 32'h0010_0093, FMT_I, 8'd1, 1'b0, 1'b0);
    checkOutput("bp1_tag",   {56'd0, tag32}, 64'd1);
    checkOutput("bp1_ready", {63'd0, inReady32}, 64'd1);
    applyStimulus(1'b1, 32'h0020_0093, FMT_I, 8'd2, 1'b0, 1'b0);
    checkOutput("bp2_tag",   {56'd0, tag32}, 64'd1);
    checkOutput("bp2_imm",   {32'd0, imm32}, 64'd1);
    checkOutput("bp2_ready", {63'd0, inReady32}, 64'd0);
    checkOutput("bp2_ready64", {63'd0, inReady64}, 64'd0);
    applyStimulus(1'b1, 32'h0030_0093, FMT_I, 8'd3, 1'b1, 1'b0);
    checkOutput("bp3_tag",   {56'd0, tag32}, 64'd2);
    checkOutput("bp3_imm",   {32'd0, imm32}, 64'd2);
    checkOutput("bp3_ready", {63'd0, inReady32}, 64'd1);
    applyStimulus(1'b1, 32'h0030_0093, FMT_I, 8'd3, 1'b1, 1'b0);
    checkOutput("bp4_tag",   {56'd0, tag32}, 64'd3);
    checkOutput("bp4_imm",   {32'd0, imm32}, 64'd3);
    applyStimulus(1'b1, 32'h0040_0093, FMT_I, 8'd4, 1'b1, 1'b0);
    checkOutput("bp5_tag",   {56'd0, tag32}, 64'd4);
    checkOutput("bp5_valid", {63'd0, outValid32}, 64'd1);
    applyStimulus(1'b0, 32'd0, FMT_R, 8'd0, 1'b1, 1'b0);
    checkOutput("bp_drain",  {63'd0, outValid32}, 64'd0);

    // Flush with both entries full and a new entry presented.
    applyStimulus(1'b1, 32'h0050_0093, FMT_I, 8'h15, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0060_0093, FMT_I, 8'h16, 1'b0, 1'b0);
    checkOutput("fl_full", {63'd0, inReady32}, 64'd0);
    applyStimulus(1'b1, 32'h0070_0093, FMT_I, 8'h17, 1'b0, 1'b1);
    checkOutput("fl_valid", {63'd0, outValid32}, 64'd0);
    checkOutput("fl_ready", {63'd0, inReady32}, 64'd1);
    applyStimulus(1'b0, 32'd0, FMT_R, 8'd0, 1'b1, 1'b0);
    checkOutput("fl_after1", {63'd0, outValid32}, 64'd0);
    // Flush wins over an accept into an empty buffer.
    applyStimulus(1'b1, 32'h0080_0093, FMT_I, 8'h18, 1'b1, 1'b1);
    checkOutput("fl_accept", {63'd0, outValid32}, 64'd0);
    applyStimulus(1'b0, 32'd0, FMT_R, 8'd0, 1'b1, 1'b0);
    checkOutput("fl_after2", {63'd0, outValid64}, 64'd0);

    // Async reset between edges with both entries full.
    applyStimulus(1'b1, 32'h7FF0_0093, FMT_I, 8'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0010_0093, FMT_I, 8'h22, 1'b0, 1'b0);
    checkOutput("ar_pre_imm", {32'd0, imm32}, 64'h7FF);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("ar_valid", {63'd0, outValid32}, 64'd0);
    checkOutput("ar_imm32", {32'd0, imm32}, 64'd0);
    checkOutput("ar_imm64", imm64, 64'd0);
    checkOutput("ar_tag",   {56'd0, tag32}, 64'd0);
    checkOutput("ar_ready", {63'd0, inReady32}, 64'd1);
    @(negedge clock);
    rstN = 1'b1;
    applyStimulus(1'b0, 32'd0, FMT_R, 8'd0, 1'b1, 1'b0);
    checkOutput("ar_after", {63'd0, outValid32}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the decode stage. Extracts and sign/zero-extends the immediate from a 25-bit instruction slice for eight instruction formats at a parameterised XLEN. Sits between fetch/decode and the ID/EX register, with a valid/ready handshake, a two-entry skid buffer and a pipeline flush. Optionally precomputes the PC-relative branch/jump target.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- TAG_W, 8, width of opaque sideband carried alongside each immediate (e.g. rd, ROB id)

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush, discards all buffered entries
- in_valid_i  in  1  input entry valid
- in_ready_o  out  1  block can accept an entry this cycle
- instr_i  in  25  instruction bits [31:7]
- type_i  in  3  format select: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 SH (shift amount)
- tag_i  in  TAG_W  sideband in
- pc_i  in  XLEN  instruction PC; present only with IMM_GEN_TARGET_EN
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  consumer accepts the output entry
- imm_o  out  XLEN  extended immediate
- tag_o  out  TAG_W  sideband out
- target_o  out  XLEN  pc_i + imm; present only with IMM_GEN_TARGET_EN

## Operation
- Immediate extraction (instruction bit numbering; s = bit 31), all sign-extended to XLEN unless stated:
  - R: 0
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}; for XLEN=64, bits 63:32 = s
  - J: {[31],[19:12],[20],[30:21],0}
  - Z: zero-extended [19:15]
  - SH: zero-extended [24:20] for XLEN=32, [25:20] for XLEN=64
- Storage: main register (drives outputs) plus one skid register. Each holds {imm, tag[, target]}.
- Accept when in_valid_i && in_ready_o. Deliver when out_valid_o && out_ready_i.
- in_ready_o = !skid_valid (registered state only; no combinational path from out_ready_i).
- Accept with main empty, or main delivering this cycle with skid empty: write main.
- Accept with main full and not delivering: write skid.
- Deliver with skid full: skid moves to main and skid clears. Input is not accepted in that cycle because in_ready_o is 0.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush.
- Flush: next edge clears main_valid and skid_valid. An entry presented in the same cycle is discarded, and flush wins over accept. Data registers keep their contents, but outputs are defined only while out_valid_o is high.

## Timing
- Latency: accepted at edge N, visible on outputs after edge N with out_valid_o=1.
- Throughput: one entry per cycle while out_ready_i is held high.
- Backpressure: out_ready_i low for one cycle leaves at most one entry in skid. in_ready_o drops the following cycle.
- out_valid_o and all payload outputs hold stable while out_valid_o && !out_ready_i.
- Reset (async assert, sync-safe deassert handled upstream):
  - out_valid_o=0, imm_o=0, tag_o=0, target_o=0
  - in_ready_o=1 during and after reset
- Reset mid-transfer discards both entries immediately.
- Simultaneous accept and deliver with main full and skid empty: the new entry lands in main and no bubble is inserted.

## Configuration
- IMM_GEN_TARGET_EN defined:
  - pc_i and target_o exist
  - target = pc_i + imm, XLEN-bit wrap-around, computed before the register
  - target is stored with the entry and follows skid transfers
- Not defined: pc_i and target_o ports are absent and no adder is built. imm/tag behaviour is identical.

## Test plan
- Formats, XLEN=32, out_ready_i=1:
  - instr=32'hFFF00093 (I) -> imm_o=32'hFFFFFFFF one cycle later
  - B encoding of offset -4 -> 32'hFFFFFFFC
  - U 32'h12345037 -> 32'h12345000
  - Z with rs1 field 5'h1F -> 32'h0000001F
- XLEN=64:
  - U 32'h80000037 -> 64'hFFFFFFFF80000000
  - SH with [25:20]=6'h3F -> 64'h3F
- Backpressure: stream tags 1,2,3,4 with out_ready_i low for cycles 2-3. Required: in_ready_o low exactly one cycle, outputs 1,2,3,4 in order, no loss, payload stable while stalled.
- Flush with both entries full and in_valid_i=1 in the same cycle. Required: next cycle out_valid_o=0, in_ready_o=1, no entry delivered afterwards.
- Async reset asserted mid-stream between clock edges. Required: out_valid_o and imm_o go to 0 immediately, in_ready_o=1.
- IMM_GEN_TARGET_EN, XLEN=32, pc_i=32'hFFFFFFF0, J immediate +32. Required: target_o=32'h00000010 (wrap-around).
